// File: rtl/ft245_sync_if_if.sv
// Signal bundle between the stream controller, ft245_sync_if and the FT232H pins.
// Latency: none, wiring only.
// Backpressure: carries rd_ready/wr_ready toward the controller and RXF#/TXE# from the chip.
// Ports: command path (read, rd_ready, data_valid, read_data), byte path (write,
// write_data, wr_ready, tx_ovf), chip side (ft_rxf_n, ft_txe_n, ft_data_i/o/oe,
// ft_rd_n, ft_wr_n, ft_oe_n, ft_siwu_n). slave = driver block, master = controller + chip.
interface ft245_sync_if_if;
    logic       read;
    logic       rd_ready;
    logic       data_valid;
    logic [7:0] read_data;
    logic       write;
    logic [7:0] write_data;
    logic       wr_ready;
    logic       tx_ovf;
    logic       ft_rxf_n;
    logic       ft_txe_n;
    logic [7:0] ft_data_i;
    logic [7:0] ft_data_o;
    logic       ft_data_oe;
    logic       ft_rd_n;
    logic       ft_wr_n;
    logic       ft_oe_n;
    logic       ft_siwu_n;

    modport slave (
        input  read, write, write_data, ft_rxf_n, ft_txe_n, ft_data_i,
        output rd_ready, data_valid, read_data, wr_ready, tx_ovf,
               ft_data_o, ft_data_oe, ft_rd_n, ft_wr_n, ft_oe_n, ft_siwu_n
    );

    modport master (
        output read, write, write_data, ft_rxf_n, ft_txe_n, ft_data_i,
        input  rd_ready, data_valid, read_data, wr_ready, tx_ovf,
               ft_data_o, ft_data_oe, ft_rd_n, ft_wr_n, ft_oe_n, ft_siwu_n
    );
endinterface

// File: rtl/ft245_sync_if.sv
// FT232H synchronous-245 byte driver: one-byte command reads, TX skid FIFO drained to the chip.
// Latency: read -> data_valid 4 clk; write -> first ft_wr_n low 2 clk (IDLE, TXE# low).
// Backpressure: wr_ready (registered) drops below 2 free slots; a write into a full FIFO is dropped and sets tx_ovf.
// Ports: clk (FT232H CLKOUT), rst (synchronous, active high), bus (ft245_sync_if_if.slave).
// Optional: define FT_SIWU_EN to pulse ft_siwu_n low once after SIWU_IDLE idle cycles following the last pop.
module ft245_sync_if #(
    parameter int TX_DEPTH  = 4,
    parameter int SIWU_IDLE = 255
) (
    input  logic           clk,
    input  logic           rst,
    ft245_sync_if_if.slave bus
);
    localparam int          AW        = $clog2(TX_DEPTH);
    localparam logic [AW:0] DEPTH_C   = (AW+1)'(TX_DEPTH);
    localparam logic [AW:0] READY_LVL = (AW+1)'(TX_DEPTH - 2);

    typedef enum logic [2:0] {IDLE, WRITE, TURN, RD_OE, RD_DATA, RD_END} state_t;

    state_t        state_q, state_d;
    logic [7:0]    mem_q [TX_DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [AW:0]   used_q, used_d;
    logic          rd_pend_q, rd_pend_d;
    logic [7:0]    read_data_q;
    logic          data_valid_q, rd_ready_q, wr_ready_q, tx_ovf_q;
    logic          full, push, pop, capture;
    logic          rd_n, wr_n, oe_n, data_oe;

    assign full   = (used_q == DEPTH_C);
    assign push   = bus.write & ~full;
    // WR# is held low for the whole WRITE state; a cycle with TXE# high is
    // ignored by the chip, so the head byte stays put and is shown again.
    assign pop    = (state_q == WRITE) & ~bus.ft_txe_n;
    assign used_d = used_q + (AW+1)'(push) - (AW+1)'(pop);

    // A failed capture (RXF# high in RD_DATA) keeps the request alive for a retry.
    assign rd_pend_d = bus.read | (rd_pend_q & ~capture);

    always_comb begin
        state_d = state_q;
        rd_n    = 1'b1;
        wr_n    = 1'b1;
        oe_n    = 1'b1;
        data_oe = 1'b0;
        capture = 1'b0;
        case (state_q)
            IDLE: begin
                if (rd_pend_q && !bus.ft_rxf_n)
                    state_d = TURN;
                else if (used_q != '0 && !bus.ft_txe_n)
                    state_d = WRITE;
            end
            WRITE: begin
                data_oe = 1'b1;
                wr_n    = 1'b0;
                // reads win at the next boundary; otherwise keep streaming
                if (rd_pend_q)
                    state_d = TURN;
                else if (used_d != '0 && !bus.ft_txe_n)
                    state_d = WRITE;
                else
                    state_d = IDLE;
            end
            // one dead cycle with nobody driving the bus before OE# falls
            TURN:  state_d = RD_OE;
            RD_OE: begin
                oe_n    = 1'b0;
                state_d = RD_DATA;
            end
            RD_DATA: begin
                oe_n = 1'b0;
                rd_n = 1'b0;
                if (!bus.ft_rxf_n) begin
                    capture = 1'b1;
                    state_d = RD_END;
                end else begin
                    state_d = IDLE;
                end
            end
            RD_END:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            rd_pend_q    <= 1'b0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            used_q       <= '0;
            read_data_q  <= '0;
            data_valid_q <= 1'b0;
            rd_ready_q   <= 1'b0;
            wr_ready_q   <= 1'b0;
            tx_ovf_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            rd_pend_q    <= rd_pend_d;
            used_q       <= used_d;
            if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            if (capture) read_data_q <= bus.ft_data_i;
            data_valid_q <= capture;
            rd_ready_q   <= ~bus.ft_rxf_n & ((state_q == IDLE) | (state_q == WRITE))
                            & ~rd_pend_q & ~bus.read;
            // room for 2 keeps one write in flight after wr_ready falls
            wr_ready_q   <= (used_d <= READY_LVL);
            if (bus.write & full) tx_ovf_q <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= bus.write_data;
    end

`ifdef FT_SIWU_EN
    localparam logic [7:0] SIWU_C = 8'(SIWU_IDLE);
    logic [7:0] siwu_cnt_q;
    logic       siwu_arm_q, siwu_n_q;

    // Armed by every pop; counts consecutive IDLE+empty cycles and fires once.
    always_ff @(posedge clk) begin
        if (rst) begin
            siwu_cnt_q <= '0;
            siwu_arm_q <= 1'b0;
            siwu_n_q   <= 1'b1;
        end else begin
            siwu_n_q <= 1'b1;
            if (pop) begin
                siwu_arm_q <= 1'b1;
                siwu_cnt_q <= '0;
            end else if (push || used_q != '0 || state_q != IDLE) begin
                siwu_cnt_q <= '0;
            end else if (siwu_arm_q) begin
                if (siwu_cnt_q + 8'd1 == SIWU_C) begin
                    siwu_n_q   <= 1'b0;
                    siwu_arm_q <= 1'b0;
                    siwu_cnt_q <= '0;
                end else begin
                    siwu_cnt_q <= siwu_cnt_q + 8'd1;
                end
            end
        end
    end
    assign bus.ft_siwu_n = siwu_n_q;
`else
    assign bus.ft_siwu_n = 1'b1;
`endif

    assign bus.ft_rd_n    = rd_n;
    assign bus.ft_wr_n    = wr_n;
    assign bus.ft_oe_n    = oe_n;
    assign bus.ft_data_oe = data_oe;
    assign bus.ft_data_o  = (state_q == WRITE) ? mem_q[rd_ptr_q] : 8'h00;
    assign bus.read_data  = read_data_q;
    assign bus.data_valid = data_valid_q;
    assign bus.rd_ready   = rd_ready_q;
    assign bus.wr_ready   = wr_ready_q;
    assign bus.tx_ovf     = tx_ovf_q;
endmodule

// File: tb/tb_ft245_sync_if.sv
// Bench for ft245_sync_if: cycle table for reads/abort, hand sequences for
// TX streaming, reset in RD_DATA, overflow/SIWU, then randomized traffic.
module tb_ft245_sync_if;
    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    ft245_sync_if_if bus ();
    ft245_sync_if #(.TX_DEPTH(DEPTH), .SIWU_IDLE(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] hbyte(input int k);
        return 8'(k * 37 + 5);
    endfunction

    // chip-side observer: bytes the chip accepts, reads it serves, bus conflicts
    logic [7:0] rxq[$];
    int rd_acc     = 0;
    int contention = 0;
    int siwu_lows  = 0;
    always @(negedge clk) begin
        if (!rst) begin
            if (!bus.ft_wr_n && !bus.ft_txe_n) rxq.push_back(bus.ft_data_o);
            if (!bus.ft_rd_n && !bus.ft_rxf_n) rd_acc++;
            if (bus.ft_data_oe && (!bus.ft_oe_n || !bus.ft_rd_n)) contention++;
            if (!bus.ft_siwu_n) siwu_lows++;
        end
    end

    typedef struct packed {
        logic       rd;
        logic       rxf_n;
        logic [7:0] din;
        logic [4:0] exp_ctl;   // {rd_n, oe_n, data_oe, data_valid, rd_ready}
        logic [7:0] exp_rdata;
    } vec_t;
    vec_t tbl[19];

    // random-phase state
    logic [7:0] txq[$];
    int nreads = 0;
    int dv_cnt = 0;
    int rd_base = 0;
    int rx_base = 0;
    logic wr_rdy_prev = 1'b0;

    task automatic rstep(input bit active);
        bus.ft_data_i = hbyte(rd_acc - rd_base);
        bus.ft_rxf_n  = active ? ($urandom_range(0, 3) == 0) : 1'b0;
        bus.ft_txe_n  = active ? ($urandom_range(0, 4) == 0) : 1'b0;
        bus.read = 1'b0;
        if (active && bus.rd_ready && nreads < 60 && $urandom_range(0, 5) == 0) begin
            bus.read = 1'b1;
            nreads++;
        end
        bus.write = 1'b0;
        if (active && (bus.wr_ready || wr_rdy_prev) && $urandom_range(0, 2) != 0) begin
            bus.write      = 1'b1;
            bus.write_data = 8'($urandom);
            txq.push_back(bus.write_data);
        end
        wr_rdy_prev = bus.wr_ready;
        tick();
        if (bus.data_valid) begin
            check($sformatf("rand_rd_data%0d", dv_cnt), {24'h0, bus.read_data}, {24'h0, hbyte(dv_cnt)});
            dv_cnt++;
        end
    endtask

    initial begin
        logic exp_wr[5];
        int   n, badcnt, sbase;

        tbl[0]  = '{1'b0, 1'b0, 8'h11, 5'b11001, 8'h00};
        tbl[1]  = '{1'b1, 1'b0, 8'h11, 5'b11000, 8'h00};
        tbl[2]  = '{1'b0, 1'b0, 8'h11, 5'b11000, 8'h00};
        tbl[3]  = '{1'b0, 1'b0, 8'h11, 5'b10000, 8'h00};
        tbl[4]  = '{1'b0, 1'b0, 8'h11, 5'b00000, 8'h00};
        tbl[5]  = '{1'b0, 1'b0, 8'h11, 5'b11010, 8'h11};
        tbl[6]  = '{1'b0, 1'b0, 8'h11, 5'b11000, 8'h11};
        tbl[7]  = '{1'b0, 1'b0, 8'h11, 5'b11001, 8'h11};
        tbl[8]  = '{1'b1, 1'b0, 8'h22, 5'b11000, 8'h11};
        tbl[9]  = '{1'b0, 1'b0, 8'h22, 5'b11000, 8'h11};
        tbl[10] = '{1'b0, 1'b0, 8'h22, 5'b10000, 8'h11};
        tbl[11] = '{1'b0, 1'b0, 8'h22, 5'b00000, 8'h11};
        tbl[12] = '{1'b0, 1'b1, 8'h22, 5'b11000, 8'h11};
        tbl[13] = '{1'b0, 1'b1, 8'h22, 5'b11000, 8'h11};
        tbl[14] = '{1'b0, 1'b0, 8'h22, 5'b11000, 8'h11};
        tbl[15] = '{1'b0, 1'b0, 8'h22, 5'b10000, 8'h11};
        tbl[16] = '{1'b0, 1'b0, 8'h22, 5'b00000, 8'h11};
        tbl[17] = '{1'b0, 1'b0, 8'h22, 5'b11010, 8'h22};
        tbl[18] = '{1'b0, 1'b0, 8'h22, 5'b11000, 8'h22};

        rst            = 1'b1;
        bus.read       = 1'b0;
        bus.write      = 1'b0;
        bus.write_data = 8'h00;
        bus.ft_rxf_n   = 1'b1;
        bus.ft_txe_n   = 1'b1;
        bus.ft_data_i  = 8'h00;
        repeat (3) tick();

        // reset values
        check("rst_strobes", {bus.ft_rd_n, bus.ft_wr_n, bus.ft_oe_n, bus.ft_siwu_n, bus.ft_data_oe}, 5'b11110);
        check("rst_data_o", bus.ft_data_o, 8'h00);
        check("rst_read_data", bus.read_data, 8'h00);
        check("rst_flags", {bus.data_valid, bus.rd_ready, bus.wr_ready, bus.tx_ovf}, 4'b0000);

        // command read, then abort and retry
        rst = 1'b0;
        for (int i = 0; i < 19; i++) begin
            bus.read      = tbl[i].rd;
            bus.ft_rxf_n  = tbl[i].rxf_n;
            bus.ft_data_i = tbl[i].din;
            tick();
            check($sformatf("read_row%0d_ctl", i),
                  {bus.ft_rd_n, bus.ft_oe_n, bus.ft_data_oe, bus.data_valid, bus.rd_ready}, tbl[i].exp_ctl);
            check($sformatf("read_row%0d_data", i), bus.read_data, tbl[i].exp_rdata);
        end

        // TX stream 0x00..0x09, one byte per clk
        bus.ft_rxf_n = 1'b1;
        bus.ft_txe_n = 1'b0;
        for (int i = 0; i < 14; i++) begin
            bus.write      = (i < 10);
            bus.write_data = 8'(i);
            tick();
            if (i >= 1 && i <= 10)
                check($sformatf("tx_stream%0d", i), {bus.ft_wr_n, bus.ft_data_oe, bus.ft_data_o}, {2'b01, 8'(i - 1)});
            else
                check($sformatf("tx_stream%0d", i), {bus.ft_wr_n, bus.ft_data_oe, bus.ft_data_o}, {2'b10, 8'h00});
        end
        check("tx_stream_ovf", bus.tx_ovf, 1'b0);

        // reset while in RD_DATA releases the bus and drops the read
        bus.ft_txe_n  = 1'b1;
        bus.ft_rxf_n  = 1'b0;
        bus.ft_data_i = 8'h5A;
        bus.read      = 1'b1;
        tick();
        bus.read = 1'b0;
        repeat (3) tick();
        check("rst_mid_in_rd_data", {bus.ft_rd_n, bus.ft_oe_n}, 2'b00);
        rst = 1'b1;
        tick();
        check("rst_mid_strobes", {bus.ft_rd_n, bus.ft_wr_n, bus.ft_oe_n, bus.ft_siwu_n, bus.ft_data_oe}, 5'b11110);
        rst    = 1'b0;
        badcnt = 0;
        repeat (8) begin
            tick();
            if (bus.data_valid || !bus.ft_rd_n) badcnt++;
        end
        check("rst_mid_read_dropped", badcnt, 0);

        // overflow with TXE# high, then drain and SIWU
        rst = 1'b1;
        tick();
        rst = 1'b0;
        bus.ft_rxf_n = 1'b1;
        tick();
        exp_wr = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        for (int i = 0; i < 5; i++) begin
            bus.write      = 1'b1;
            bus.write_data = 8'(8'hA0 + i);
            tick();
            check($sformatf("ovf_wr_ready%0d", i), bus.wr_ready, exp_wr[i]);
            check($sformatf("ovf_flag%0d", i), bus.tx_ovf, (i == 4));
        end
        bus.write    = 1'b0;
        rx_base      = rxq.size();
        sbase        = siwu_lows;
        bus.ft_txe_n = 1'b0;
        repeat (40) tick();
        n = rxq.size() - rx_base;
        check("ovf_drain_count", n, 4);
        for (int k = 0; k < 4 && k < n; k++)
            check($sformatf("ovf_drain_byte%0d", k), rxq[rx_base + k], 8'(8'hA0 + k));
        check("ovf_sticky", bus.tx_ovf, 1'b1);
`ifdef FT_SIWU_EN
        check("siwu_pulses", siwu_lows - sbase, 1);
`else
        check("siwu_pulses", siwu_lows - sbase, 0);
`endif

        // randomized traffic against the stream-level model
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        rd_base = rd_acc;
        rx_base = rxq.size();
        repeat (3000) rstep(1'b1);
        repeat (300) rstep(1'b0);
        check("rand_read_count", dv_cnt, nreads);
        n = rxq.size() - rx_base;
        check("rand_tx_count", n, txq.size());
        for (int k = 0; k < txq.size() && k < n; k++)
            check($sformatf("rand_tx_byte%0d", k), rxq[rx_base + k], txq[k]);
        check("rand_tx_ovf", bus.tx_ovf, 1'b0);
        check("rand_wr_ready_recovers", bus.wr_ready, 1'b1);
        check("bus_contention", contention, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
